// File: rtl/pwm_action_dead_band_if.sv
// Signal bundle between the PWM timebase/register block and the action/dead-band output stage.
interface pwm_action_dead_band_if #(
  parameter int CTR_W = 12,
  parameter int DB_W  = 8
);
  logic             out_en;
  logic [CTR_W-1:0] ctr;
  logic             ctr_0;
  logic             cmp_wr;
  logic [CTR_W-1:0] cmp_data;
  logic             db_wr;
  logic [DB_W-1:0]  db_data;
  logic             pwm_a;
  logic             pwm_b;
  logic [CTR_W-1:0] cmp_active;
  logic             cmp_evt;
  logic             zero_evt;

  modport master (
    output out_en, ctr, ctr_0, cmp_wr, cmp_data, db_wr, db_data,
    input  pwm_a, pwm_b, cmp_active, cmp_evt, zero_evt
  );

  modport slave (
    input  out_en, ctr, ctr_0, cmp_wr, cmp_data, db_wr, db_data,
    output pwm_a, pwm_b, cmp_active, cmp_evt, zero_evt
  );
endinterface

// File: rtl/pwm_action_dead_band.sv
// PWM action stage: shadowed duty compare builds a raw waveform, which a dead-band FSM
// turns into complementary high/low-side drives that are never on together.
module pwm_action_dead_band #(
  parameter int CTR_W = 12,
  parameter int DB_W  = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  pwm_action_dead_band_if.slave bus
);

  typedef enum logic [2:0] {
    ST_OFF,
    ST_LOW,
    ST_RISE_DLY,
    ST_HIGH,
    ST_FALL_DLY
  } state_t;

  state_t           state_reg;
  logic [CTR_W-1:0] cmp_shadow_reg;
  logic [CTR_W-1:0] cmp_active_reg;
  logic [CTR_W-1:0] eff_cmp;
  logic [DB_W-1:0]  db_reg;
  logic [DB_W-1:0]  dly_cnt_reg;
  logic             raw_reg;
  logic             raw_next;
  logic             match;
  logic             pwm_a_reg;
  logic             pwm_b_reg;
  logic             cmp_evt_reg;
  logic             zero_evt_reg;

  // On the zero cycle the shadow value is the one becoming active, so match against it.
  assign eff_cmp = bus.ctr_0 ? cmp_shadow_reg : cmp_active_reg;
  assign match   = (bus.ctr == eff_cmp);

  always_comb begin
    raw_next = raw_reg;
    if (!bus.out_en)
      raw_next = 1'b0;
    else if (match)
      raw_next = 1'b0;
    else if (bus.ctr_0)
      raw_next = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_shadow_reg <= '0;
      cmp_active_reg <= '0;
      db_reg         <= '0;
      raw_reg        <= 1'b0;
      cmp_evt_reg    <= 1'b0;
      zero_evt_reg   <= 1'b0;
    end else begin
      if (bus.cmp_wr)
        cmp_shadow_reg <= bus.cmp_data;
      if (bus.ctr_0)
        cmp_active_reg <= cmp_shadow_reg;
      if (bus.db_wr)
        db_reg <= bus.db_data;
      raw_reg      <= raw_next;
      cmp_evt_reg  <= match;
      zero_evt_reg <= bus.ctr_0;
    end
  end

  // Drive outputs are updated together with the state so they always mirror it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_OFF;
      dly_cnt_reg <= '0;
      pwm_a_reg   <= 1'b0;
      pwm_b_reg   <= 1'b0;
    end else if (!bus.out_en) begin
      state_reg <= ST_OFF;
      pwm_a_reg <= 1'b0;
      pwm_b_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_OFF: begin
          state_reg <= ST_LOW;
          pwm_a_reg <= 1'b0;
          pwm_b_reg <= 1'b1;
        end
        ST_LOW: begin
          if (raw_reg) begin
            pwm_b_reg <= 1'b0;
            if (db_reg == '0) begin
              state_reg <= ST_HIGH;
              pwm_a_reg <= 1'b1;
            end else begin
              state_reg   <= ST_RISE_DLY;
              dly_cnt_reg <= db_reg;
              pwm_a_reg   <= 1'b0;
            end
          end
        end
        ST_RISE_DLY: begin
          if (!raw_reg) begin
            state_reg <= ST_LOW;
            pwm_a_reg <= 1'b0;
            pwm_b_reg <= 1'b1;
          end else if (dly_cnt_reg == DB_W'(1)) begin
            state_reg <= ST_HIGH;
            pwm_a_reg <= 1'b1;
            pwm_b_reg <= 1'b0;
          end else begin
            dly_cnt_reg <= dly_cnt_reg - 1'b1;
          end
        end
        ST_HIGH: begin
          if (!raw_reg) begin
            pwm_a_reg <= 1'b0;
            if (db_reg == '0) begin
              state_reg <= ST_LOW;
              pwm_b_reg <= 1'b1;
            end else begin
              state_reg   <= ST_FALL_DLY;
              dly_cnt_reg <= db_reg;
              pwm_b_reg   <= 1'b0;
            end
          end
        end
        ST_FALL_DLY: begin
          if (raw_reg) begin
            state_reg <= ST_HIGH;
            pwm_a_reg <= 1'b1;
            pwm_b_reg <= 1'b0;
          end else if (dly_cnt_reg == DB_W'(1)) begin
            state_reg <= ST_LOW;
            pwm_a_reg <= 1'b0;
            pwm_b_reg <= 1'b1;
          end else begin
            dly_cnt_reg <= dly_cnt_reg - 1'b1;
          end
        end
        default: begin
          state_reg <= ST_OFF;
          pwm_a_reg <= 1'b0;
          pwm_b_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pwm_a      = pwm_a_reg;
  assign bus.pwm_b      = pwm_b_reg;
  assign bus.cmp_active = cmp_active_reg;
  assign bus.cmp_evt    = cmp_evt_reg;
  assign bus.zero_evt   = zero_evt_reg;

endmodule
